// File: rtl/uart_frame_if.sv
// Byte strobe input and frame results between the UART receiver,
// the frame parser and its register/response consumers.
interface uart_frame_if;
  logic [7:0] uart_data;
  logic       uart_done;
  logic [7:0] rev_data0;
  logic [7:0] rev_data1;
  logic [7:0] rev_data2;
  logic [7:0] rev_data3;
  logic [7:0] rev_data4;
  logic [7:0] rev_data5;
  logic [7:0] rev_data6;
  logic [7:0] rev_data7;
  logic [7:0] rev_data8;
  logic [7:0] rev_data9;
  logic [7:0] rev_data10;
  logic       pack_done;
  logic       recv_done;
  logic       pack_ing;
  logic [7:0] pack_cnt;
  logic [7:0] response_data;
  logic [7:0] pack_num;

  modport master (
    output uart_data, uart_done,
    input  rev_data0, rev_data1, rev_data2, rev_data3,
    input  rev_data4, rev_data5, rev_data6, rev_data7,
    input  rev_data8, rev_data9, rev_data10,
    input  pack_done, recv_done, pack_ing,
    input  pack_cnt, response_data, pack_num
  );

  modport slave (
    input  uart_data, uart_done,
    output rev_data0, rev_data1, rev_data2, rev_data3,
    output rev_data4, rev_data5, rev_data6, rev_data7,
    output rev_data8, rev_data9, rev_data10,
    output pack_done, recv_done, pack_ing,
    output pack_cnt, response_data, pack_num
  );
endinterface

// File: rtl/uart_frame_parser.sv
// 13-byte UART frame parser: header, CRC-8 (0x07) and inter-byte
// timeout checks; commits registers only on good frames.
module uart_frame_parser #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] RESP_OK     = 8'h80
) (
  input logic         sys_clk,
  input logic         sys_rst,
  uart_frame_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] RESP_CRC = 8'hE1;
  localparam logic [7:0] RESP_TO  = 8'hE2;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   tcnt;
  logic [7:0]      crc;
  logic [7:0]      crc_nx;
  logic            crc_ok;
  logic [7:0]      shadow [11];
  logic [3:0]      slot;
  logic            tout;
  logic            last;
  logic            hdr;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign crc_nx = crc8(crc, bus.uart_data);
  assign slot   = 4'(bus.pack_num - 8'd1);
  assign tout   = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign last   = (bus.pack_num == 8'd12);
  assign hdr    = bus.uart_done && (bus.uart_data == HEADER);

  assign bus.pack_ing = (state != IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hdr) state_nx = RECV;
      RECV: begin
        if (bus.uart_done && last) state_nx = CHECK;
        else if (!bus.uart_done && tout) state_nx = IDLE;
      end
      CHECK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tcnt              <= '0;
      crc               <= '0;
      crc_ok            <= 1'b0;
      for (int i = 0; i < 11; i++)
        shadow[i] <= '0;
      bus.rev_data0     <= '0;
      bus.rev_data1     <= '0;
      bus.rev_data2     <= '0;
      bus.rev_data3     <= '0;
      bus.rev_data4     <= '0;
      bus.rev_data5     <= '0;
      bus.rev_data6     <= '0;
      bus.rev_data7     <= '0;
      bus.rev_data8     <= '0;
      bus.rev_data9     <= '0;
      bus.rev_data10    <= '0;
      bus.pack_done     <= 1'b0;
      bus.recv_done     <= 1'b0;
      bus.pack_cnt      <= '0;
      bus.response_data <= '0;
      bus.pack_num      <= '0;
    end else begin
      bus.pack_done <= 1'b0;
      bus.recv_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (hdr) begin
            crc          <= '0;
            bus.pack_num <= 8'd1;
          end
        end
        RECV: begin
          if (bus.uart_done) begin
            tcnt         <= '0;
            bus.pack_num <= bus.pack_num + 8'd1;
            if (last) begin
              crc_ok <= (bus.uart_data == crc);
            end else begin
              shadow[slot] <= bus.uart_data;
              crc          <= crc_nx;
            end
          end else if (tout) begin
            // Abandon the frame; the shadow buffer is simply never copied.
            tcnt              <= '0;
            bus.pack_num      <= '0;
            bus.response_data <= RESP_TO;
            bus.recv_done     <= 1'b1;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          bus.pack_num  <= '0;
          bus.recv_done <= 1'b1;
          if (crc_ok) begin
            bus.rev_data0     <= shadow[0];
            bus.rev_data1     <= shadow[1];
            bus.rev_data2     <= shadow[2];
            bus.rev_data3     <= shadow[3];
            bus.rev_data4     <= shadow[4];
            bus.rev_data5     <= shadow[5];
            bus.rev_data6     <= shadow[6];
            bus.rev_data7     <= shadow[7];
            bus.rev_data8     <= shadow[8];
            bus.rev_data9     <= shadow[9];
            bus.rev_data10    <= shadow[10];
            bus.response_data <= RESP_OK;
            bus.pack_cnt      <= bus.pack_cnt + 8'd1;
            bus.pack_done     <= 1'b1;
          end else begin
            bus.response_data <= RESP_CRC;
          end
        end
        default: tcnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-to-frame parser between the UART byte receiver and `uart_reg_mapper`, in the `sys_clk` (50 MHz) domain. It checks the header, the fixed 13-byte frame length, the inter-byte timeout and the CRC-8 of each frame. It drives `rev_data0..10`, `pack_done` and `response_data` to the register mapper and to `uart_protocol_tx`. Register outputs update only on frames that pass every check.

## Interface
- `_HEADER`, 8'hA5, frame start byte
- `_TIMEOUT_CYC`, 50000, max `sys_clk` cycles between bytes inside a frame (1 ms at 50 MHz)
- `_RESP_OK`, 8'h80, `response_data` for a good frame
- `sys_clk` input 1: system clock; the only clock
- `sys_rst` input 1: reset, asynchronous, active-high
- `uart_data` input 8: received byte, valid when `uart_done`=1
- `uart_done` input 1: one-cycle byte strobe
- `rev_data0` output 8: function byte of last good frame
- `rev_data1..rev_data10` output 8 each: payload bytes of last good frame
- `pack_done` output 1: one-cycle pulse, new good frame committed
- `recv_done` output 1: one-cycle pulse on every frame end (good, CRC error, or timeout)
- `pack_ing` output 1: high while a frame is in progress (RECV/CHECK)
- `pack_cnt` output 8: good-frame counter, wraps 255→0
- `response_data` output 8: status of last frame end
- `pack_num` output 8: byte index within current frame (0 = header)

## Operation
- Frame layout: byte0 = `_HEADER`, byte1 = func, bytes 2..11 = data1..data10, byte12 = CRC.
- CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR. It covers bytes 1..11 only, not the header.
- CRC update is one byte per strobe: 8 unrolled shift/XOR steps, combinational, registered on `uart_done`.
- States: IDLE, RECV, CHECK.
- IDLE:
  - `uart_done` with `_HEADER`: clear the CRC, set `pack_num`=1, go to RECV.
  - Any other byte is discarded silently.
- RECV:
  - Each `uart_done` stores the byte into shadow buffer slot `pack_num-1` (bytes 1..11), updates the CRC, increments `pack_num`, and clears the timeout counter.
  - Byte 12 is compared against the running CRC; go to CHECK.
  - A byte value equal to `_HEADER` inside RECV is ordinary data and does not resync.
- Timeout:
  - The counter increments every cycle in RECV and clears on `uart_done`.
  - When it reaches `_TIMEOUT_CYC`-1: abort, `response_data`=8'hE2, pulse `recv_done`, go to IDLE.
  - Shadow buffer contents are discarded and `rev_data*` is unchanged.
- CHECK (exactly one cycle):
  - CRC match: copy the shadow buffer to `rev_data0..10`, `response_data`=`_RESP_OK`, `pack_cnt`+1, pulse `pack_done` and `recv_done`.
  - Mismatch: `response_data`=8'hE1, pulse `recv_done` only, `rev_data*` unchanged.
  - Always return to IDLE and set `pack_num`=0.
- A `uart_done` arriving during CHECK is dropped. The UART byte spacing (≥434 cycles) makes this a non-event in normal use.
- `pack_ing` = 1 in RECV and CHECK.

## Timing
- Reset (async assert, sync deassert by upstream): state IDLE; all outputs 0, including `rev_data*`, `response_data`=8'h00, `pack_cnt`=0, `pack_num`=0. Timeout counter and CRC are 0.
- Reset asserted mid-frame: the frame is lost and no pulses are emitted.
- Latency: CRC byte strobe at cycle N → CHECK at N+1.
  - `rev_data*`, `response_data`, `pack_cnt`, `pack_done` and `recv_done` are all registered and visible at N+2.
  - Pulses last exactly one cycle.
- Timeout: `recv_done` is high exactly `_TIMEOUT_CYC`+1 cycles after the last accepted byte strobe.
- `rev_data*` is stable from one `pack_done` until the next; downstream may sample it on `pack_done`.
- `pack_done` and `recv_done` are never asserted in the same cycle as a state change to RECV.
- Timeout counter width: `$clog2(_TIMEOUT_CYC)`. It saturates and never wraps.

## Test plan
- Good frame: A5, 00, nine×00, 01, CRC 07 → at N+2 `pack_done`=1 and `recv_done`=1 for 1 cycle, `rev_data10`=0x01, others 0x00, `response_data`=0x80, `pack_cnt`=1.
- CRC error: same frame with CRC 08 → `recv_done` pulse only, `response_data`=0xE1, `rev_data*` hold the previous values, `pack_cnt` unchanged.
- Garbage then frame: 12, 34, then all-zero frame A5, eleven×00, CRC 00 → the leading bytes are ignored; `pack_done` pulses; all `rev_data*`=0x00.
- Timeout: A5, 01, 02, then silence with `_TIMEOUT_CYC`=100 → `recv_done` 101 cycles after the last strobe, `response_data`=0xE2, `pack_ing` falls. A following good frame parses correctly.
- Counter wrap: 256 consecutive good frames → `pack_cnt` returns to 0x00, with 256 `pack_done` pulses counted.
- Async reset asserted at byte 7 of a frame → all outputs 0 immediately. After release, a complete good frame gives `pack_cnt`=1.
